// File: rtl/pll_ctrl_pkg.sv
// Shared types and code helpers for the rPLL dynamic controller.
// Divider-to-code mapping for the Gowin rPLL dynamic select inputs lives here.
package pll_ctrl_pkg;

  typedef enum logic [2:0] {
    RST_HOLD,
    WAIT_LOCK,
    STABLE,
    RUN,
    FAIL
  } state_e;

  typedef struct packed {
    logic [5:0] idsel;
    logic [5:0] fbdsel;
    logic [5:0] odsel;
  } pll_cfg_t;

  // 53 MHz from 50 MHz: IDIV_SEL 12, FBDIV_SEL 13, ODIV 16
  localparam logic [5:0] DEF53_IDSEL  = 6'd51;
  localparam logic [5:0] DEF53_FBDSEL = 6'd50;
  localparam logic [5:0] DEF53_ODSEL  = 6'd56;

  function automatic logic [5:0] div_to_idsel(
    input logic [5:0] sel
  );
    return 6'd63 - sel;
  endfunction

  function automatic logic [5:0] div_to_fbdsel(
    input logic [5:0] sel
  );
    return 6'd63 - sel;
  endfunction

  function automatic logic [5:0] div_to_odsel(
    input logic [6:0] odiv
  );
    logic [6:0] t;
    t = 7'd64 - (odiv >> 1);
    return t[5:0];
  endfunction

endpackage

// File: rtl/pll_lock_sync.sv
// Two-flop synchronizer for rPLL LOCK plus a consecutive-lock counter.
// lock_stable flags the STABLE_N-th consecutive synced-lock cycle since clr.
module pll_lock_sync #(
  parameter int unsigned STABLE_N = 1024
) (
  input  logic clk,
  input  logic reset,
  input  logic lock_async,
  input  logic clr,
  output logic lock_sync,
  output logic lock_stable
);

  localparam int unsigned CW =
    (STABLE_N > 1) ? $clog2(STABLE_N) : 1;
  localparam logic [CW-1:0] CMAX = CW'(STABLE_N - 1);

  logic [1:0]    sync_q, sync_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // shift the raw lock in; count clean cycles, saturating
  always_comb begin
    sync_d = {sync_q[0], lock_async};
    cnt_d  = cnt_q;
    if (clr || !sync_q[1]) begin
      cnt_d = '0;
    end else if (cnt_q != CMAX) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // synchronizer and counter registers
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q <= '0;
      cnt_q  <= '0;
    end else begin
      sync_q <= sync_d;
      cnt_q  <= cnt_d;
    end
  end

  assign lock_sync   = sync_q[1];
  assign lock_stable = sync_q[1] && !clr &&
                       (cnt_q == CMAX);

endmodule

// File: rtl/pll_dyn_ctrl.sv
// Sequencer for one rPLL with dynamic dividers: reset, lock wait,
// debounce, run, retune handshake, automatic re-lock and retry/fail.
module pll_dyn_ctrl
  import pll_ctrl_pkg::*;
#(
  parameter logic [5:0]  DEF_IDSEL    = DEF53_IDSEL,
  parameter logic [5:0]  DEF_FBDSEL   = DEF53_FBDSEL,
  parameter logic [5:0]  DEF_ODSEL    = DEF53_ODSEL,
  parameter int unsigned RST_CYCLES   = 16,
  parameter int unsigned LOCK_STABLE  = 1024,
  parameter int unsigned LOCK_TIMEOUT = 65536,
  parameter int unsigned MAX_RETRY    = 3
) (
  input  logic       clkin,
  input  logic       reset,
  input  logic       pll_lock,
  output logic       pll_reset,
  output logic [5:0] pll_idsel,
  output logic [5:0] pll_fbdsel,
  output logic [5:0] pll_odsel,
  input  logic       cfg_valid,
  output logic       cfg_ready,
  input  logic [5:0] cfg_idsel,
  input  logic [5:0] cfg_fbdsel,
  input  logic [5:0] cfg_odsel,
  output logic       clk_ok,
  output logic       busy,
  output logic       err,
  output logic [7:0] relock_cnt
);

  localparam int unsigned RW =
    (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
  localparam int unsigned TW =
    (LOCK_TIMEOUT > 1) ? $clog2(LOCK_TIMEOUT) : 1;
  localparam int unsigned YW = $clog2(MAX_RETRY + 1);

  state_e        state_q, state_d;
  logic [RW-1:0] rcnt_q, rcnt_d;
  logic [TW-1:0] tmr_q, tmr_d;
  logic [YW-1:0] retry_q, retry_d;
  logic          err_q, err_d;
  logic [7:0]    relock_q, relock_d;
  pll_cfg_t      cfg_q, cfg_d;

  logic lock_sync;
  logic lock_stable;
  logic xfer;

  pll_lock_sync #(
    .STABLE_N (LOCK_STABLE)
  ) u_sync (
    .clk         (clkin),
    .reset       (reset),
    .lock_async  (pll_lock),
    .clr         (state_q != STABLE),
    .lock_sync   (lock_sync),
    .lock_stable (lock_stable)
  );

  assign cfg_ready  = (state_q == RUN) ||
                      (state_q == FAIL);
  assign busy       = !cfg_ready;
  assign pll_reset  = (state_q == RST_HOLD) ||
                      (state_q == FAIL);
  assign clk_ok     = (state_q == RUN) && lock_sync;
  assign err        = err_q;
  assign relock_cnt = relock_q;
  assign pll_idsel  = cfg_q.idsel;
  assign pll_fbdsel = cfg_q.fbdsel;
  assign pll_odsel  = cfg_q.odsel;
  assign xfer       = cfg_valid && cfg_ready;

  // next state; an accepted retune overrides the state decision
  always_comb begin
    state_d  = state_q;
    rcnt_d   = rcnt_q;
    tmr_d    = tmr_q;
    retry_d  = retry_q;
    err_d    = err_q;
    relock_d = relock_q;
    cfg_d    = cfg_q;
    unique case (state_q)
      RST_HOLD: begin
        tmr_d = '0;
        if (rcnt_q == RW'(RST_CYCLES - 1)) begin
          rcnt_d  = '0;
          state_d = WAIT_LOCK;
        end else begin
          rcnt_d = rcnt_q + 1'b1;
        end
      end
      WAIT_LOCK: begin
        if (lock_sync) begin
          state_d = STABLE;
        end else if (tmr_q == TW'(LOCK_TIMEOUT - 1)) begin
          tmr_d   = '0;
          retry_d = retry_q + 1'b1;
          if (retry_q >= YW'(MAX_RETRY - 1)) begin
            state_d = FAIL;
            err_d   = 1'b1;
          end else begin
            state_d = RST_HOLD;
          end
        end else begin
          tmr_d = tmr_q + 1'b1;
        end
      end
      STABLE: begin
        if (!lock_sync) begin
          state_d = WAIT_LOCK;
        end else if (lock_stable) begin
          state_d = RUN;
          retry_d = '0;
        end
      end
      RUN: begin
        if (!lock_sync) begin
          state_d = RST_HOLD;
          rcnt_d  = '0;
          if (relock_q != 8'hff) begin
            relock_d = relock_q + 1'b1;
          end
        end
      end
      FAIL: begin
        err_d = 1'b1;
      end
      default: begin
        state_d = RST_HOLD;
      end
    endcase
    if (xfer) begin
      cfg_d   = '{idsel:  cfg_idsel,
                  fbdsel: cfg_fbdsel,
                  odsel:  cfg_odsel};
      state_d = RST_HOLD;
      rcnt_d  = '0;
      tmr_d   = '0;
      retry_d = '0;
      err_d   = 1'b0;
    end
  end

  // state and datapath registers
  always_ff @(posedge clkin) begin
    if (reset) begin
      state_q  <= RST_HOLD;
      rcnt_q   <= '0;
      tmr_q    <= '0;
      retry_q  <= '0;
      err_q    <= 1'b0;
      relock_q <= '0;
      cfg_q    <= '{idsel:  DEF_IDSEL,
                    fbdsel: DEF_FBDSEL,
                    odsel:  DEF_ODSEL};
    end else begin
      state_q  <= state_d;
      rcnt_q   <= rcnt_d;
      tmr_q    <= tmr_d;
      retry_q  <= retry_d;
      err_q    <= err_d;
      relock_q <= relock_d;
      cfg_q    <= cfg_d;
    end
  end

endmodule

// File: tb/tb_pll_dyn_ctrl.sv
// Directed bench for pll_dyn_ctrl: vector table for power-up,
// glitch and timeout, hand sequences for retune, lock loss and reset.
module tb_pll_dyn_ctrl;
  import pll_ctrl_pkg::*;

  logic       clkin = 1'b0;
  logic       reset = 1'b1;
  logic       pll_lock = 1'b0;
  logic       cfg_valid = 1'b0;
  logic [5:0] cfg_idsel = 6'd40;
  logic [5:0] cfg_fbdsel = 6'd20;
  logic [5:0] cfg_odsel = 6'd60;
  logic       pll_reset, cfg_ready, clk_ok, busy, err;
  logic [5:0] pll_idsel, pll_fbdsel, pll_odsel;
  logic [7:0] relock_cnt;

  int errors = 0;
  int checks = 0;

  pll_dyn_ctrl #(
    .RST_CYCLES   (4),
    .LOCK_STABLE  (8),
    .LOCK_TIMEOUT (32),
    .MAX_RETRY    (2)
  ) dut (
    .clkin      (clkin),
    .reset      (reset),
    .pll_lock   (pll_lock),
    .pll_reset  (pll_reset),
    .pll_idsel  (pll_idsel),
    .pll_fbdsel (pll_fbdsel),
    .pll_odsel  (pll_odsel),
    .cfg_valid  (cfg_valid),
    .cfg_ready  (cfg_ready),
    .cfg_idsel  (cfg_idsel),
    .cfg_fbdsel (cfg_fbdsel),
    .cfg_odsel  (cfg_odsel),
    .clk_ok     (clk_ok),
    .busy       (busy),
    .err        (err),
    .relock_cnt (relock_cnt)
  );

  always #5 clkin = ~clkin;

  typedef struct packed {
    logic       pr, ok, bz, rd, er;
    logic [7:0] rc;
    logic [5:0] id, fb, od;
  } obs_t;

  typedef struct {
    string name;
    logic  rst, lock, vld;
    int    n;
    obs_t  exp;
  } vec_t;

  vec_t tbl[$];

  localparam logic [17:0] D = {6'd51, 6'd50, 6'd56};
  localparam logic [17:0] T = {6'd40, 6'd20, 6'd60};
  localparam logic [17:0] U = {6'd10, 6'd11, 6'd12};

  // hold/reset, waiting, running, failed
  function automatic obs_t H(logic [7:0] rc, logic [17:0] s);
    return obs_t'({5'b10100, rc, s});
  endfunction
  function automatic obs_t W(logic [7:0] rc, logic [17:0] s);
    return obs_t'({5'b00100, rc, s});
  endfunction
  function automatic obs_t R(logic [7:0] rc, logic [17:0] s);
    return obs_t'({5'b01010, rc, s});
  endfunction
  function automatic obs_t F(logic [7:0] rc, logic [17:0] s);
    return obs_t'({5'b10011, rc, s});
  endfunction

  function automatic obs_t sample();
    return obs_t'({pll_reset, clk_ok, busy, cfg_ready, err,
                   relock_cnt, pll_idsel, pll_fbdsel, pll_odsel});
  endfunction

  task automatic step(input int n);
    repeat (n) @(posedge clkin);
    #1;
  endtask

  task automatic chk(input string nm, input obs_t a,
                     input obs_t e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %h want %h", nm, a, e);
    end
  endtask

  task automatic chkv(input string nm, input logic [31:0] a,
                      input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %0d want %0d", nm, a, e);
    end
  endtask

  task automatic add(input string nm, input logic r,
                     input logic l, input logic v,
                     input int n, input obs_t e);
    tbl.push_back('{nm, r, l, v, n, e});
  endtask

  task automatic wait_ok(input string nm, input int lim);
    for (int i = 0; i < lim && !clk_ok; i++) step(1);
    chkv(nm, clk_ok, 1);
  endtask

  task automatic bring_up();
    reset = 1'b1;
    pll_lock = 1'b0;
    cfg_valid = 1'b0;
    step(3);
    reset = 1'b0;
    pll_lock = 1'b1;
    wait_ok("bring_up", 60);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1);
  end

  initial begin
    int xfers;
    int lat;

    // power-up: lock at cycle 10, clk_ok 9 after synced lock
    add("a_rst",  1, 0, 0, 2,  H(0, D));
    add("a_hold", 0, 0, 0, 3,  H(0, D));
    add("a_wait", 0, 0, 0, 1,  W(0, D));
    add("a_w9",   0, 0, 0, 5,  W(0, D));
    add("a_sync", 0, 1, 0, 2,  W(0, D));
    add("a_pre",  0, 1, 0, 8,  W(0, D));
    add("a_run",  0, 1, 0, 1,  R(0, D));
    // glitchy lock: 5 high, 1 low, then high
    add("b_rst",  1, 0, 0, 3,  H(0, D));
    add("b_w9",   0, 0, 0, 9,  W(0, D));
    add("b_hi5",  0, 1, 0, 5,  W(0, D));
    add("b_lo1",  0, 0, 0, 1,  W(0, D));
    add("b_hi2",  0, 1, 0, 2,  W(0, D));
    add("b_r20",  0, 1, 0, 3,  W(0, D));
    add("b_r25",  0, 1, 0, 5,  W(0, D));
    add("b_run",  0, 1, 0, 1,  R(0, D));
    // two timeout rounds, then FAIL; retune leaves FAIL
    add("c_rst",  1, 0, 0, 3,  H(0, D));
    add("c_w35",  0, 0, 0, 35, W(0, D));
    add("c_h36",  0, 0, 0, 1,  H(0, D));
    add("c_h39",  0, 0, 0, 3,  H(0, D));
    add("c_w40",  0, 0, 0, 1,  W(0, D));
    add("c_w71",  0, 0, 0, 31, W(0, D));
    add("c_fail", 0, 0, 0, 1,  F(0, D));
    add("c_stay", 0, 0, 0, 20, F(0, D));
    add("c_tune", 0, 0, 1, 1,  H(0, T));
    add("c_lk",   0, 1, 0, 12, W(0, T));
    add("c_run",  0, 1, 0, 1,  R(0, T));

    foreach (tbl[i]) begin
      reset = tbl[i].rst;
      pll_lock = tbl[i].lock;
      cfg_valid = tbl[i].vld;
      step(tbl[i].n);
      chk(tbl[i].name, sample(), tbl[i].exp);
    end
    cfg_valid = 1'b0;

    // retune in RUN with valid held 3 cycles
    bring_up();
    chk("rt_pre", sample(), R(0, D));
    {cfg_idsel, cfg_fbdsel, cfg_odsel} = T;
    cfg_valid = 1'b1;
    xfers = 0;
    for (int k = 0; k < 3; k++) begin
      if (cfg_valid && cfg_ready) xfers++;
      step(1);
      if (k == 0) chk("rt_next", sample(), H(0, T));
    end
    cfg_valid = 1'b0;
    chkv("rt_xfers", xfers, 1);
    wait_ok("rt_relock", 40);
    chk("rt_run", sample(), R(0, T));

    // lock loss in RUN
    pll_lock = 1'b0;
    lat = 0;
    for (int k = 0; k < 3 && clk_ok; k++) begin
      step(1);
      lat++;
    end
    chkv("ll_clk_ok", clk_ok, 0);
    chkv("ll_lat_le3", lat <= 3, 1);
    step(1);
    chk("ll_hold", sample(), H(1, T));
    pll_lock = 1'b1;
    wait_ok("ll_relock", 40);
    chk("ll_run", sample(), R(1, T));

    // reset mid-STABLE after a retune to 10/11/12
    {cfg_idsel, cfg_fbdsel, cfg_odsel} = U;
    cfg_valid = 1'b1;
    step(1);
    cfg_valid = 1'b0;
    step(6);
    chk("rs_stable", sample(), W(1, U));
    reset = 1'b1;
    step(1);
    chk("rs_reset", sample(), H(0, D));
    reset = 1'b0;

    // reset mid-retune: valid still high when reset hits
    bring_up();
    {cfg_idsel, cfg_fbdsel, cfg_odsel} = T;
    cfg_valid = 1'b1;
    step(1);
    chk("rr_tune", sample(), H(0, T));
    reset = 1'b1;
    step(1);
    chk("rr_reset", sample(), H(0, D));
    reset = 1'b0;
    cfg_valid = 1'b0;
    wait_ok("rr_relock", 40);
    chk("rr_run", sample(), R(0, D));

    // lock loss and retune in the same RUN cycle
    pll_lock = 1'b0;
    step(2);
    chkv("lr_ready", {clk_ok, cfg_ready}, 2'b01);
    cfg_valid = 1'b1;
    step(1);
    cfg_valid = 1'b0;
    chk("lr_both", sample(), H(1, T));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
